// File: rtl/systolic_pkg.sv
// Shared types and sizing helper for the systolic result streamer.
package systolic_pkg;

    typedef enum logic {IDLE, SEND} rstream_state_e;

    typedef enum logic {ROW_MAJOR, COL_MAJOR} rstream_order_e;

    function automatic int unsigned beats(input int unsigned n, input int unsigned elem_w,
                                          input int unsigned bus_w);
        int unsigned epb;
        epb = bus_w / elem_w;
        return (n * n + epb - 1) / epb;
    endfunction

endpackage

// File: rtl/rstream_index_map.sv
// Maps a streaming sequence index to the flat element offset (r*N+c) of the captured matrix.
module rstream_index_map #(
    parameter int unsigned N     = 4,
    parameter int unsigned IDX_W = 5
) (
    input  logic [IDX_W-1:0] seq_idx,
    input  logic             col_major,
    output logic [IDX_W-1:0] elem_off
);

    logic [IDX_W-1:0] quot;
    logic [IDX_W-1:0] rem;

    // Row-major offset is the index itself; column-major swaps the roles of quotient and remainder.
    always_comb begin
        quot     = seq_idx / IDX_W'(N);
        rem      = seq_idx % IDX_W'(N);
        elem_off = col_major ? (rem * IDX_W'(N) + quot) : seq_idx;
    end

endmodule

// File: rtl/systolic_result_streamer.sv
// Captures an N x N result matrix and streams it as BUS_W-bit beats, row- or column-major.
// Define RSTREAM_DOUBLE_BUF_EN to add a shadow buffer so back-to-back matrices stream gaplessly.
module systolic_result_streamer
    import systolic_pkg::*;
#(
    parameter int unsigned N      = 4,
    parameter int unsigned ELEM_W = 32,
    parameter int unsigned BUS_W  = 64
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  res_valid,
    output logic                  res_ready,
    input  logic [N*N*ELEM_W-1:0] res_data,
    input  logic                  col_major,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [BUS_W-1:0]      data_out,
    output logic                  out_last,
    output logic                  tx_done
);

    localparam int unsigned EPB    = BUS_W / ELEM_W;
    localparam int unsigned BEATS  = beats(N, ELEM_W, BUS_W);
    localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned IDX_W  = $clog2(BEATS * EPB + 1);
    localparam int unsigned MAT_W  = N * N * ELEM_W;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

    if (BUS_W % ELEM_W != 0) begin : g_bad_bus_w
        $error("BUS_W must be a multiple of ELEM_W");
    end

    rstream_state_e    state_q, state_d;
    rstream_order_e    order_q, order_d;
    logic [MAT_W-1:0]  buf_q, buf_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic              res_ready_q, res_ready_d;
    logic              out_valid_q, out_valid_d;
    logic              out_last_q, out_last_d;
    logic              tx_done_q, tx_done_d;
    logic [BUS_W-1:0]  data_out_q, data_out_d;
    logic [BUS_W-1:0]  beat_data;
    logic              capture, fire, last_fire;
`ifdef RSTREAM_DOUBLE_BUF_EN
    rstream_order_e    shadow_order_q, shadow_order_d;
    logic [MAT_W-1:0]  shadow_q, shadow_d;
    logic              shadow_full_q, shadow_full_d;
`endif

    always_comb begin
        state_d     = state_q;
        order_d     = order_q;
        buf_d       = buf_q;
        beat_d      = beat_q;
        res_ready_d = res_ready_q;
        out_valid_d = out_valid_q;
        tx_done_d   = 1'b0;
`ifdef RSTREAM_DOUBLE_BUF_EN
        shadow_d       = shadow_q;
        shadow_order_d = shadow_order_q;
        shadow_full_d  = shadow_full_q;
`endif
        capture   = res_valid && res_ready_q;
        fire      = out_valid_q && out_ready;
        last_fire = fire && (beat_q == LAST_BEAT);

        unique case (state_q)
            IDLE: begin
                res_ready_d = 1'b1;
                out_valid_d = 1'b0;
                if (capture) begin
                    buf_d       = res_data;
                    order_d     = col_major ? COL_MAJOR : ROW_MAJOR;
                    beat_d      = '0;
                    state_d     = SEND;
                    out_valid_d = 1'b1;
`ifdef RSTREAM_DOUBLE_BUF_EN
                    res_ready_d = 1'b1;
`else
                    res_ready_d = 1'b0;
`endif
                end
            end
            SEND: begin
`ifdef RSTREAM_DOUBLE_BUF_EN
                if (capture) begin
                    shadow_d       = res_data;
                    shadow_order_d = col_major ? COL_MAJOR : ROW_MAJOR;
                    shadow_full_d  = 1'b1;
                end
`endif
                if (last_fire) begin
                    tx_done_d = 1'b1;
`ifdef RSTREAM_DOUBLE_BUF_EN
                    // A pending shadow (even one captured this cycle) starts immediately.
                    if (shadow_full_d) begin
                        buf_d         = shadow_d;
                        order_d       = shadow_order_d;
                        beat_d        = '0;
                        shadow_full_d = 1'b0;
                    end else begin
                        state_d     = IDLE;
                        out_valid_d = 1'b0;
                    end
`else
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
`endif
                end else if (fire) begin
                    beat_d = beat_q + 1'b1;
                end
`ifdef RSTREAM_DOUBLE_BUF_EN
                res_ready_d = !shadow_full_d;
`else
                res_ready_d = (state_d == IDLE);
`endif
            end
            default: ;
        endcase

        if (flush) begin
            state_d     = IDLE;
            beat_d      = '0;
            out_valid_d = 1'b0;
            tx_done_d   = 1'b0;
            res_ready_d = 1'b1;
`ifdef RSTREAM_DOUBLE_BUF_EN
            shadow_full_d = 1'b0;
`endif
        end
    end

    // Next beat is assembled from next-state buffer and counter so every output stays registered.
    for (genvar l = 0; l < EPB; l++) begin : g_lane
        logic [IDX_W-1:0] seq_idx;
        logic [IDX_W-1:0] elem_off;

        assign seq_idx = IDX_W'(beat_d) * IDX_W'(EPB) + IDX_W'(l);

        rstream_index_map #(
            .N    (N),
            .IDX_W(IDX_W)
        ) u_index_map (
            .seq_idx  (seq_idx),
            .col_major(order_d == COL_MAJOR),
            .elem_off (elem_off)
        );

        assign beat_data[l*ELEM_W +: ELEM_W] =
            (seq_idx < IDX_W'(N * N)) ? buf_d[elem_off*ELEM_W +: ELEM_W] : '0;
    end

    always_comb begin
        out_last_d = out_valid_d && (beat_d == LAST_BEAT);
        data_out_d = out_valid_d ? beat_data : data_out_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            order_q     <= ROW_MAJOR;
            buf_q       <= '0;
            beat_q      <= '0;
            res_ready_q <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            tx_done_q   <= 1'b0;
            data_out_q  <= '0;
        end else begin
            state_q     <= state_d;
            order_q     <= order_d;
            buf_q       <= buf_d;
            beat_q      <= beat_d;
            res_ready_q <= res_ready_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            tx_done_q   <= tx_done_d;
            data_out_q  <= data_out_d;
        end
    end

`ifdef RSTREAM_DOUBLE_BUF_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shadow_q       <= '0;
            shadow_order_q <= ROW_MAJOR;
            shadow_full_q  <= 1'b0;
        end else begin
            shadow_q       <= shadow_d;
            shadow_order_q <= shadow_order_d;
            shadow_full_q  <= shadow_full_d;
        end
    end
`endif

    assign res_ready = res_ready_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign tx_done   = tx_done_q;
    assign data_out  = data_out_q;

endmodule

// File: tb/tb_systolic_result_streamer.sv
// Randomized self-checking bench for systolic_result_streamer against a queue-based beat model.
// Define RSTREAM_DOUBLE_BUF_EN for both bench and RTL to exercise the shadow buffer.
module tb_systolic_result_streamer;

    localparam int N      = 4;
    localparam int ELEM_W = 32;
    localparam int BUS_W  = 64;
    localparam int EPB    = BUS_W / ELEM_W;
    localparam int BEATS  = (N * N + EPB - 1) / EPB;
    localparam int MAT_W  = N * N * ELEM_W;
`ifdef RSTREAM_DOUBLE_BUF_EN
    localparam bit DOUBLE = 1'b1;
`else
    localparam bit DOUBLE = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             res_valid = 1'b0;
    logic             res_ready;
    logic [MAT_W-1:0] res_data = '0;
    logic             col_major = 1'b0;
    logic             flush = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [BUS_W-1:0] data_out;
    logic             out_last;
    logic             tx_done;

    always #5 clk = ~clk;

    systolic_result_streamer #(
        .N     (N),
        .ELEM_W(ELEM_W),
        .BUS_W (BUS_W)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .res_valid(res_valid),
        .res_ready(res_ready),
        .res_data (res_data),
        .col_major(col_major),
        .flush    (flush),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .data_out (data_out),
        .out_last (out_last),
        .tx_done  (tx_done)
    );

    typedef struct packed {
        logic [BUS_W-1:0] data;
        logic             last;
    } beat_t;

    beat_t            exp_q[$];
    logic [BUS_W-1:0] acc_log[$];
    int               n_vec = 0;
    int               n_err = 0;
    int               tx_count = 0;
    logic             exp_tx = 1'b0;
    logic             exp_rdy = 1'b0;
    logic             prev_stall = 1'b0;
    logic [BUS_W-1:0] prev_data = '0;
    int               ready_mode = 0;
    int               ready_cnt = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Expected beats straight from the ordering and lane-packing rules.
    function automatic void push_matrix(input logic [MAT_W-1:0] m, input logic col);
        for (int b = 0; b < BEATS; b++) begin
            beat_t bt;
            bt.data = '0;
            for (int l = 0; l < EPB; l++) begin
                int i = b * EPB + l;
                if (i < N * N) begin
                    int r = col ? i % N : i / N;
                    int c = col ? i / N : i % N;
                    bt.data[l*ELEM_W +: ELEM_W] = m[(r*N+c)*ELEM_W +: ELEM_W];
                end
            end
            bt.last = (b == BEATS - 1);
            exp_q.push_back(bt);
        end
    endfunction

    always @(negedge clk) begin
        if (!reset_n) begin
            check("rst_res_ready", 64'(res_ready), 64'(0));
            check("rst_out_valid", 64'(out_valid), 64'(0));
            check("rst_out_last", 64'(out_last), 64'(0));
            check("rst_tx_done", 64'(tx_done), 64'(0));
            check("rst_data_out", data_out, 64'(0));
            exp_q.delete();
            exp_tx     = 1'b0;
            exp_rdy    = 1'b0;
            prev_stall = 1'b0;
        end else begin
            check("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
            check("res_ready", 64'(res_ready), 64'(exp_rdy));
            check("tx_done", 64'(tx_done), 64'(exp_tx));
            if (prev_stall) check("stall_hold", data_out, prev_data);
            if (out_valid && exp_q.size() != 0) begin
                check("data_out", data_out, exp_q[0].data);
                check("out_last", 64'(out_last), 64'(exp_q[0].last));
            end
            if (tx_done) tx_count++;
            exp_tx     = 1'b0;
            prev_stall = out_valid && !out_ready && !flush;
            prev_data  = data_out;
            if (flush) begin
                exp_q.delete();
            end else begin
                if (out_valid && out_ready && exp_q.size() != 0) begin
                    acc_log.push_back(data_out);
                    exp_tx = exp_q[0].last;
                    void'(exp_q.pop_front());
                end
                if (res_valid && res_ready) push_matrix(res_data, col_major);
            end
            exp_rdy = DOUBLE ? (exp_q.size() <= BEATS) : (exp_q.size() == 0);
        end
    end

    always @(posedge clk) begin
        #1;
        ready_cnt++;
        case (ready_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = (ready_cnt % 3 == 0);
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
    end

    task automatic send(input logic [MAT_W-1:0] m, input logic col);
        @(posedge clk);
        #1;
        res_valid = 1'b1;
        res_data  = m;
        col_major = col;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (res_ready) break;
        end
        check("send_accepted", 64'(res_ready), 64'(1));
        @(posedge clk);
        #1;
        res_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            #1;
            if (exp_q.size() == 0 && !out_valid) break;
        end
        check("idle_queue", 64'(exp_q.size()), 64'(0));
        check("idle_valid", 64'(out_valid), 64'(0));
    endtask

    task automatic pulse_flush();
        @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [MAT_W-1:0] seq_m;
        logic [MAT_W-1:0] rnd_m;
        for (int e = 0; e < N * N; e++) seq_m[e*ELEM_W +: ELEM_W] = ELEM_W'(e);

        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Row-major, always ready.
        ready_mode = 0;
        acc_log.delete();
        tx_count = 0;
        send(seq_m, 1'b0);
        wait_idle(100);
        check("t1_count", 64'(acc_log.size()), 64'(8));
        check("t1_beat0", acc_log[0], 64'h00000001_00000000);
        check("t1_beat7", acc_log[7], 64'h0000000F_0000000E);
        check("t1_tx", 64'(tx_count), 64'(1));
        check("t1_res_ready", 64'(res_ready), 64'(1));

        // Column-major.
        acc_log.delete();
        send(seq_m, 1'b1);
        wait_idle(100);
        check("t2_beat0", acc_log[0], 64'h00000004_00000000);
        check("t2_beat1", acc_log[1], 64'h0000000C_00000008);
        check("t2_beat7", acc_log[7], 64'h0000000F_0000000B);

        // Stalling sink: 1,0,0 ready pattern.
        ready_mode = 1;
        acc_log.delete();
        send(seq_m, 1'b0);
        wait_idle(200);
        check("t3_count", 64'(acc_log.size()), 64'(8));
        for (int b = 0; b < 8; b++)
            check("t3_beat", acc_log[b], {32'(2 * b + 1), 32'(2 * b)});

        // Flush once beat 3 has been accepted.
        ready_mode = 0;
        acc_log.delete();
        tx_count = 0;
        send(seq_m, 1'b0);
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            #1;
            if (acc_log.size() >= 4) break;
        end
        pulse_flush();
        wait_idle(20);
        check("t4_count", 64'(acc_log.size()), 64'(4));
        check("t4_no_tx", 64'(tx_count), 64'(0));
        acc_log.delete();
        send(seq_m, 1'b1);
        wait_idle(100);
        check("t4_restart", acc_log[0], 64'h00000004_00000000);
        check("t4_tx", 64'(tx_count), 64'(1));

        // Asynchronous reset mid-stream.
        send(seq_m, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        check("t5_out_valid", 64'(out_valid), 64'(0));
        check("t5_res_ready", 64'(res_ready), 64'(0));
        check("t5_out_last", 64'(out_last), 64'(0));
        check("t5_tx_done", 64'(tx_done), 64'(0));
        check("t5_data_out", data_out, 64'(0));
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        acc_log.delete();
        send(seq_m, 1'b0);
        wait_idle(100);
        check("t5_restart", acc_log[0], 64'h00000001_00000000);

`ifdef RSTREAM_DOUBLE_BUF_EN
        // Second matrix captured into the shadow while the first streams.
        ready_mode = 0;
        acc_log.delete();
        tx_count = 0;
        send(seq_m, 1'b0);
        send(seq_m, 1'b1);
        wait_idle(200);
        check("t6_count", 64'(acc_log.size()), 64'(16));
        check("t6_tx", 64'(tx_count), 64'(2));
        check("t6_second_beat0", acc_log[8], 64'h00000004_00000000);
`endif

        // Random matrices, orderings, sink behaviour and occasional flushes.
        for (int t = 0; t < 30; t++) begin
            for (int e = 0; e < N * N; e++) rnd_m[e*ELEM_W +: ELEM_W] = $urandom;
            ready_mode = int'($urandom_range(0, 2));
            send(rnd_m, 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 4) == 0) begin
                repeat ($urandom_range(0, 10)) @(posedge clk);
                pulse_flush();
            end
        end
        wait_idle(600);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
